ahb_rr_arbiter: RTL
===================

# ahb_rr_arbiter

Parametrised AHB bus arbiter for the multi-manager interconnect. It grants one of `MANAGERS` requesting managers per address phase, with round-robin or fixed-priority selection. A bounded hold counter provides burst tenure, and a lock input supports atomic sequences. A registered data-phase owner vector follows the AHB address/data pipeline. All state advances only on `hready`-qualified edges.

## Interface
- `MANAGERS`, default 4: number of managers; must be ≥ 2.
- `MAX_HOLD`, default 8: maximum consecutive accepted cycles an unlocked owner keeps the grant while others request; must be ≥ 1.
- `MODE`, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `requestV` in `MANAGERS`: per-manager bus request.
- `lockV` in `MANAGERS`: per-manager lock (HMASTLOCK-style); it is honoured only for the current owner.
- `hready` in 1: bus transfer accepted this cycle.
- `grantedV` out `MANAGERS`: one-hot address-phase grant, or all-zero when idle.
- `grant_idx` out `$clog2(MANAGERS)`: binary index of the owner; 0 when idle.
- `grant_valid` out 1: high when `grantedV` is non-zero.
- `data_ownerV` out `MANAGERS`: one-hot data-phase owner, which is `grantedV` delayed by one accepted cycle.

## Operation
- State registers:
  - `grantedV` and `grant_idx`.
  - `ptr`: index of the last newly granted manager.
  - `hold_cnt`: saturating count of accepted cycles of the current tenure.
  - `data_ownerV`.
- Reset values: `grantedV`=0, `grant_idx`=0, `grant_valid`=0, `data_ownerV`=0, `ptr`=`MANAGERS`-1, `hold_cnt`=0.
- Rising edge with `reset`=1: load the reset values, regardless of `hready`.
- Rising edge with `hready`=0: all state holds. No regrant happens, the counter does not advance, and the data owner does not shift.
- Rising edge with `hready`=1:
  - `data_ownerV` ← the current `grantedV`.
  - **Keep**: an owner exists, `requestV[owner]`=1, and either `lockV[owner]`=1 or `hold_cnt` < `MAX_HOLD`-1. The owner is unchanged; `hold_cnt` increments, saturating at `MAX_HOLD`-1.
  - **Re-arbitrate**: in every other case, select a winner from `requestV`.
    - MODE 0: scan indices `ptr`+1, `ptr`+2, … modulo `MANAGERS`, ending with `ptr` itself. The first requester wins.
    - MODE 1: the lowest-index requester wins.
    - If a winner exists: `grantedV` ← one-hot(winner), `grant_idx` ← winner, `ptr` ← winner, `hold_cnt` ← 0.
    - If no manager requests: `grantedV` ← 0, `grant_idx` ← 0, `hold_cnt` ← 0, and `ptr` is unchanged.
- After hold expiry the owner is re-granted only if no other manager is requesting (MODE 0), or if it is the lowest requester (MODE 1).
  - When re-granted, `hold_cnt` restarts at 0.
  - MODE 1 starvation of high indices is intended.
- A locked owner is never preempted. A lock asserted by a non-owner has no effect.
- An owner that drops its request loses the grant at the next accepted edge, even mid-tenure.
- `requestV` and `lockV` are sampled only at accepted edges. Changes while `hready`=0 are ignored until `hready`=1.
- Invariants: `grantedV` and `data_ownerV` are always one-hot or zero. `grant_valid` equals the OR-reduction of `grantedV`.

## Timing
- All outputs are registered; no combinational path runs from inputs to outputs.
- Grant latency: a request sampled at accepted edge n appears on `grantedV` after edge n, in the next cycle.
- Data-phase latency: `data_ownerV` equals `grantedV` after the next accepted edge.
- Tenure: an unlocked owner facing competition holds for exactly `MAX_HOLD` accepted cycles.
- Wait states (`hready`=0) stretch a tenure without consuming hold count.
- Reset mid-burst: after the reset edge all outputs are 0.
  - The first grant afterwards occurs one accepted edge after reset deasserts.
  - That grant starts scanning at index 0.

## Test plan
All scenarios use `MANAGERS`=4 and `MAX_HOLD`=4.
1. MODE 0, reset then `requestV`=4'b1111, `hready`=1, `lockV`=0 → `grantedV` shows 0001×4, 0010×4, 0100×4, 1000×4, then 0001. `data_ownerV` trails by one cycle and `grant_idx` tracks 0,1,2,3.
2. MODE 0, `requestV`=4'b1010 from reset → 0010×4, 1000×4, 0010×4. Then `requestV` changes to 4'b0001 → the next accepted edge gives 0001 and `grant_valid`=1.
3. MODE 0, owner 0001 with `requestV`=4'b1111, `hready`=0 for 6 cycles after hold_cnt=1 → `grantedV` and `data_ownerV` are frozen. After `hready` returns, owner 0001 remains for exactly 3 more accepted cycles, then the grant moves to 0010.
4. Owner 0100 with `lockV`=4'b0100 and `requestV`=4'b1111 for 10 accepted cycles → the grant stays 0100 throughout. Clearing `lockV` after hold_cnt has saturated → the grant moves to 1000 at the next accepted edge.
5. MODE 1, `requestV`=4'b1110 → 0010 held indefinitely, re-granted after each expiry. Then `requestV` changes to 4'b1111 mid-tenure → 0001 after the current tenure expires.
6. Owner 0010 drops its request with `requestV`=0 → after the next accepted edge `grantedV`=0, `grant_idx`=0, `grant_valid`=0. Then assert `reset` for one cycle mid-tenure with `hready`=0 → all outputs are 0 after the edge. With `requestV`=4'b1111 afterwards, the first grant is 0001.

Source files
------------

// File: rtl/ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter
//
// AHB bus arbiter for the multi-manager interconnect. One of MANAGERS
// requesting managers owns the address phase at a time. Selection is
// round-robin (MODE 0) or fixed priority with the lowest index winning
// (MODE 1). An unlocked owner keeps the bus for at most MAX_HOLD accepted
// cycles. A locked owner is never preempted. A registered data-phase owner
// vector trails the address-phase grant by one accepted cycle.
//
// Transfer acceptance: hready is the only qualifier. A rising edge with
// hready=1 is an "accepted edge". On that edge requestV and lockV are
// sampled and all state advances. A rising edge with hready=0 changes no
// state, and request or lock changes seen during it are ignored. reset
// overrides hready.
//
// Parameters:
//   MANAGERS  number of managers (>= 2)
//   MAX_HOLD  accepted cycles an unlocked owner keeps the grant under
//             competition (>= 1)
//   MODE      0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   requestV     per-manager bus request
//   lockV        per-manager lock; honoured only for the current owner
//   hready       transfer accepted this cycle
//   grantedV     one-hot address-phase grant, or zero when idle
//   grant_idx    binary index of the owner, or 0 when idle
//   grant_valid  OR-reduction of grantedV
//   data_ownerV  one-hot data-phase owner (grantedV delayed by one
//                accepted cycle)
// ---------------------------------------------------------------------------
module ahb_rr_arbiter #(
  parameter int MANAGERS = 4,
  parameter int MAX_HOLD = 8,
  parameter int MODE     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [MANAGERS-1:0]         requestV,
  input  logic [MANAGERS-1:0]         lockV,
  input  logic                        hready,
  output logic [MANAGERS-1:0]         grantedV,
  output logic [$clog2(MANAGERS)-1:0] grant_idx,
  output logic                        grant_valid,
  output logic [MANAGERS-1:0]         data_ownerV
);

  localparam int IW = $clog2(MANAGERS);
  // hold_cnt only needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [IW-1:0]       PTR_RESET = IW'(MANAGERS - 1);
  localparam logic [HW-1:0]       HOLD_SAT  = HW'(MAX_HOLD - 1);
  localparam logic [MANAGERS-1:0] ONE_HOT0  = {{(MANAGERS-1){1'b0}}, 1'b1};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [IW-1:0]       ptr;       // index of the last newly granted manager
  logic [HW-1:0]       hold_cnt;  // accepted cycles of the current tenure

  logic [MANAGERS-1:0] granted_d;
  logic [IW-1:0]       idx_d;
  logic [IW-1:0]       ptr_d;
  logic [HW-1:0]       hold_d;
  logic [MANAGERS-1:0] data_owner_d;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
  logic          any_req;
  logic          rr_found;
  logic [IW-1:0] rr_win;
  logic [IW-1:0] rr_cand;
  logic [IW-1:0] fp_win;
  logic [IW-1:0] fp_cand;
  logic [IW-1:0] win;

  assign any_req = |requestV;

  // Round-robin: the scan starts just after ptr and wraps, so ptr itself is
  // the last candidate. This is what lets an expired owner be re-granted
  // only when nobody else is asking.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_cand  = '0;
    for (int off = 1; off <= MANAGERS; off++) begin
      rr_cand = IW'((int'(ptr) + off) % MANAGERS);
      if (!rr_found && requestV[rr_cand]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand;
      end
    end
  end

  // Fixed priority: walk from the top down so the lowest requester is the
  // last one written.
  always_comb begin
    fp_win  = '0;
    fp_cand = '0;
    for (int i = MANAGERS - 1; i >= 0; i--) begin
      fp_cand = IW'(i);
      if (requestV[fp_cand]) begin
        fp_win = fp_cand;
      end
    end
  end

  assign win = (MODE == 1) ? fp_win : rr_win;

  // -------------------------------------------------------------------------
  // Tenure decision
  // -------------------------------------------------------------------------
  logic owner_present;
  logic owner_req;
  logic owner_lock;
  logic keep;

  assign owner_present = |grantedV;
  assign owner_req     = requestV[grant_idx];
  assign owner_lock    = lockV[grant_idx];

  // The owner keeps the bus while it still requests and either holds the
  // lock or has not yet used up its MAX_HOLD accepted cycles. A lock raised
  // by any other manager is never looked at.
  assign keep = owner_present && owner_req &&
                (owner_lock || (hold_cnt < HOLD_SAT));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    granted_d    = grantedV;
    idx_d        = grant_idx;
    ptr_d        = ptr;
    hold_d       = hold_cnt;
    data_owner_d = data_ownerV;

    if (hready) begin
      data_owner_d = grantedV;
      if (keep) begin
        // A locked owner can outlive MAX_HOLD, so the count saturates.
        if (hold_cnt != HOLD_SAT) begin
          hold_d = hold_cnt + HW'(1);
        end
      end else if (any_req) begin
        granted_d = ONE_HOT0 << win;
        idx_d     = win;
        ptr_d     = win;
        hold_d    = '0;
      end else begin
        // Idle bus: ptr is left alone so round-robin fairness survives gaps.
        granted_d = '0;
        idx_d     = '0;
        hold_d    = '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      grantedV    <= '0;
      grant_idx   <= '0;
      ptr         <= PTR_RESET;
      hold_cnt    <= '0;
      data_ownerV <= '0;
    end else begin
      grantedV    <= granted_d;
      grant_idx   <= idx_d;
      ptr         <= ptr_d;
      hold_cnt    <= hold_d;
      data_ownerV <= data_owner_d;
    end
  end

  // Derived only from a register, so it is still a registered output.
  assign grant_valid = |grantedV;

endmodule
